bcd_serial_add_ctrl: RTL and testbench
======================================

// Module: bcd_serial_add_ctrl
// PURPOSE
//   Sequences one single-digit BCD add stage over a DIGITS-wide packed BCD operand pair, LSD first, one digit per clock.
//   Digit carry is held in a register between cycles. Upstream/downstream use valid/ready handshakes.
//   Sits between operand source (e.g. keypad/register file) and result consumer (e.g. 7-seg display driver).
// PARAMETERS
//   DIGITS  4  number of BCD digits per operand (>=1); operand width = 4*DIGITS
// PORTS
//   clk        in   1         single clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         operand pair valid
//   in_ready   out  1         controller can accept operands
//   a          in   4*DIGITS  operand A, packed BCD, digit 0 = a[3:0]
//   b          in   4*DIGITS  operand B, packed BCD
//   cin        in   1         carry into digit 0
//   out_valid  out  1         result valid
//   out_ready  in   1         consumer accepts result
//   sum        out  4*DIGITS  packed BCD result
//   cout       out  1         carry out of MSD
//   busy       out  1         high in ADD or DONE
//   err        out  1         invalid-digit flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; busy=0; err=0; digit index=0; carry reg=0.
//   - FSM: IDLE -> ADD on in_valid&&in_ready; ADD -> DONE after digit DIGITS-1 is processed; DONE -> IDLE on out_valid&&out_ready.
//   - in_ready=1 only in IDLE; in_valid ignored in ADD/DONE. No accept in the same cycle as output handshake.
//   - Accept edge: latch a, b into shift registers, carry reg<=cin, index<=0, err<=0 (with macro: err<=0 before scan).
//   - ADD, each cycle, for digit d=index: t = a_d + b_d + carry (5 bit). If t>9: digit=(t+6) mod 16, carry<=1; else digit=t[3:0], carry<=0.
//     Digit shifted into sum from MSD side so digit d lands at sum[4d+3:4d] after last step; index++.
//   - Latency: accept at edge N -> out_valid=1 after edge N+DIGITS; sum/cout stable from then until output handshake.
//   - cout = carry reg after digit DIGITS-1.
//   - DONE: out_valid=1, sum/cout held while out_ready=0 (no limit). Handshake edge: out_valid<=0, state IDLE, sum/cout retain value.
//   - Result 10^DIGITS wraps: 9..9 + 0..1 gives sum 0, cout 1.
//   - Reset mid-ADD or mid-DONE: immediate return to reset values; partial result discarded, no out_valid.
//   - DIGITS=1: ADD lasts exactly one cycle.
// CONFIGURATION
//   Macro BCD_INVALID_CHECK_EN.
//   - Defined: each digit of a and b checked as processed; any digit >9 sets err (sticky for the operation),
//     err valid with out_valid, cleared at next accept. Arithmetic unchanged (result undefined-but-deterministic per rule above).
//   - Undefined: err tied 0; no check logic; invalid digits processed by the same rule.
// TESTING
//   1. DIGITS=4, a=16'h1234, b=16'h5678, cin=0 -> after 4 cycles out_valid=1, sum=16'h6912, cout=0.
//   2. a=16'h9999, b=16'h0001, cin=0 -> sum=16'h0000, cout=1; a=16'h0000, b=16'h0000, cin=1 -> sum=16'h0001, cout=0.
//   3. a=16'h0999, b=16'h0001 with out_ready=0 for 5 cycles -> sum=16'h1000, cout=0 held, out_valid stays 1, in_ready=0 until handshake.
//   4. in_valid held high during ADD with different a/b -> ignored; result matches first operands; next op accepted only after return to IDLE.
//   5. rst_n pulsed low at ADD cycle 2 -> out_valid=0, busy=0, in_ready=1 immediately (async); next op 16'h0005+16'h0005 -> sum=16'h0010.
//   6. BCD_INVALID_CHECK_EN defined, a=16'h000A, b=16'h0000 -> err=1 with out_valid; next valid op clears err=0. Undefined: err=0.

Source files
------------

// File: rtl/bcd_serial_add_ctrl_if.sv
// bcd_serial_add_ctrl_if
//   Bundles the operand and result handshakes of the serial BCD adder
//   controller. Clock and reset are kept as plain ports on the controller.
//
//   Signals (DIGITS BCD digits per operand):
//     in_valid   source -> ctrl   operand pair valid
//     in_ready   ctrl -> source   controller can accept operands
//     a, b       source -> ctrl   packed BCD operands, digit 0 in [3:0]
//     cin        source -> ctrl   carry into digit 0
//     out_valid  ctrl -> sink     result valid
//     out_ready  sink -> ctrl     consumer accepts result
//     sum        ctrl -> sink     packed BCD result
//     cout       ctrl -> sink     carry out of the most significant digit
//     busy       ctrl -> sink     operation in progress or result pending
//     err        ctrl -> sink     invalid-digit flag
//
//   Modports: master = operand source / result consumer, slave = controller.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  busy;
  logic                  err;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, err
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, err
  );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
//   Adds two DIGITS-wide packed BCD operands one digit per clock, least
//   significant digit first, keeping the inter-digit carry in a register.
//   Operands arrive over a valid/ready handshake; the result is offered over
//   a second valid/ready handshake and held until the consumer takes it.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    bcd_serial_add_ctrl_if.slave (in_valid/in_ready/a/b/cin,
//            out_valid/out_ready/sum/cout, busy, err)
//
//   Optional feature: define BCD_INVALID_CHECK_EN to flag operand digits
//   greater than 9 on err (sticky for one operation, cleared at the next
//   accept). Without the macro err is tied low and no check logic exists.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input logic                clk,
  input logic                rst_n,
  bcd_serial_add_ctrl_if.slave bus
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      aSh_q, aSh_d;
  logic [W-1:0]      bSh_q, bSh_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  logic [4:0]        digitSum;
  logic [4:0]        digitAdj;
  logic [3:0]        digitOut;
  logic              digitCarry;
  logic [W+3:0]      sumWide;
  logic              lastDigit;

  // Single-digit BCD stage on the low nibble of the operand shift registers.
  // A raw sum above 9 is corrected by adding 6 and dropping bit 4; that same
  // rule is applied unchanged to non-BCD input digits.
  always_comb begin
    digitSum   = {1'b0, aSh_q[3:0]} + {1'b0, bSh_q[3:0]} + {4'b0000, carry_q};
    digitAdj   = digitSum + 5'd6;
    digitOut   = digitSum[3:0];
    digitCarry = 1'b0;
    if (digitSum > 5'd9) begin
      digitOut   = digitAdj[3:0];
      digitCarry = 1'b1;
    end
    // New digit enters from the MSD side, so after DIGITS steps digit d
    // sits at sum[4d+3:4d]. The widened vector keeps DIGITS=1 legal.
    sumWide   = {digitOut, sum_q};
    lastDigit = (idx_q == IDXW'(DIGITS - 1));
  end

  // Next-state and datapath control. Accept happens only in IDLE, so an
  // operand can never be taken on the same edge as a result handshake.
  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = ADD;
          aSh_d   = bus.a;
          bSh_d   = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
        end
      end
      ADD: begin
        aSh_d   = aSh_q >> 4;
        bSh_d   = bSh_q >> 4;
        carry_d = digitCarry;
        sum_d   = sumWide[W+3:4];
        idx_d   = idx_q + 1'b1;
        if (lastDigit) begin
          state_d = DONE;
          cout_d  = digitCarry;
          idx_d   = '0;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  logic err_q, err_d;

  // Sticky invalid-digit flag: cleared when a new operand pair is accepted,
  // set by any a or b digit above 9 as it passes through the adder stage.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && bus.in_valid) begin
      err_d = 1'b0;
    end else if (state_q == ADD && (aSh_q[3:0] > 4'd9 || bSh_q[3:0] > 4'd9)) begin
      err_d = 1'b1;
    end
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl
//   Self-checking bench for bcd_serial_add_ctrl with DIGITS=4. Expected
//   results come from a decimal reference model, are queued when an operand
//   pair is accepted and compared when the result is presented.
//   Honours BCD_INVALID_CHECK_EN for the expected err value.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct packed {
    logic         err;
    logic         cout;
    logic [W-1:0] sum;
  } expect_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  expect_t expQ[$];
  int checks = 0;
  int failures = 0;

  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Hard stop in case something waits forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One comparison: count it, report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int bcdToInt(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      r = r * 10 + int'(v[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] intToBcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal reference: wrap at 10^DIGITS, carry out when the total reaches it.
  function automatic expect_t model(input logic [W-1:0] opA, input logic [W-1:0] opB, input logic opCin);
    expect_t e;
    int lim = 1;
    int total;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    total  = bcdToInt(opA) + bcdToInt(opB) + int'(opCin);
    e.err  = 1'b0;
    e.cout = (total >= lim);
    e.sum  = intToBcd(total % lim);
    return e;
  endfunction

  // Present one operand pair, wait for the accept edge, optionally queue the
  // model result. Returns #1 after the accept edge.
  task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB, input logic opCin,
                               input bit keepValid, input bit pushModel);
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("inReadyBeforeAccept", bus.in_ready, 1);
    bus.a        = opA;
    bus.b        = opB;
    bus.cin      = opCin;
    bus.in_valid = 1'b1;
    if (pushModel) expQ.push_back(model(opA, opB, opCin));
    @(posedge clk);
    #1;
    if (!keepValid) bus.in_valid = 1'b0;
    checkOutput("busyAfterAccept", bus.busy, 1);
    checkOutput("inReadyInAdd", bus.in_ready, 0);
  endtask

  // Wait for the result, hold off the consumer for holdCycles, compare with
  // the scoreboard head, then complete the output handshake.
  task automatic collectResult(input int holdCycles);
    expect_t e;
    int cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("latency", cycles, DIGITS);
    e = expQ.pop_front();
    repeat (holdCycles) begin
      @(negedge clk);
      checkOutput("holdOutValid", bus.out_valid, 1);
      checkOutput("holdSum", bus.sum, e.sum);
      checkOutput("holdCout", bus.cout, e.cout);
      checkOutput("holdInReady", bus.in_ready, 0);
    end
    @(negedge clk);
    checkOutput("sum", bus.sum, e.sum);
    checkOutput("cout", bus.cout, e.cout);
    checkOutput("err", bus.err, e.err);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("outValidAfterHandshake", bus.out_valid, 0);
    checkOutput("sumRetained", bus.sum, e.sum);
    checkOutput("inReadyAfterHandshake", bus.in_ready, 1);
  endtask

  // Main sequence.
  initial begin
    expect_t e;
    logic [W-1:0] ra, rb;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;

    #12;
    checkOutput("resetInReady", bus.in_ready, 1);
    checkOutput("resetOutValid", bus.out_valid, 0);
    checkOutput("resetBusy", bus.busy, 0);
    checkOutput("resetSum", bus.sum, 0);
    checkOutput("resetCout", bus.cout, 0);
    checkOutput("resetErr", bus.err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic additions");
    applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1);
    collectResult(0);
    applyStimulus(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b1);
    collectResult(0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
    collectResult(0);

    $display("[TB] consumer backpressure");
    applyStimulus(16'h0999, 16'h0001, 1'b0, 1'b0, 1'b1);
    collectResult(5);

    $display("[TB] in_valid held during ADD");
    applyStimulus(16'h4321, 16'h1111, 1'b0, 1'b1, 1'b1);
    bus.a   = 16'h8888;
    bus.b   = 16'h7777;
    bus.cin = 1'b1;
    expQ.push_back(model(16'h8888, 16'h7777, 1'b1));
    collectResult(2);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("secondOpBusy", bus.busy, 1);
    collectResult(0);

    $display("[TB] reset during ADD");
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetOutValid", bus.out_valid, 0);
    checkOutput("midResetBusy", bus.busy, 0);
    checkOutput("midResetInReady", bus.in_ready, 1);
    checkOutput("midResetSum", bus.sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1);
    collectResult(0);

    $display("[TB] invalid digit");
    applyStimulus(16'h000A, 16'h0000, 1'b0, 1'b0, 1'b0);
    e.sum  = 16'h0010;
    e.cout = 1'b0;
`ifdef BCD_INVALID_CHECK_EN
    e.err  = 1'b1;
`else
    e.err  = 1'b0;
`endif
    expQ.push_back(e);
    collectResult(0);
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    collectResult(0);

    $display("[TB] random operands");
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(9, 0));
        rb[4*i +: 4] = 4'($urandom_range(9, 0));
      end
      applyStimulus(ra, rb, 1'($urandom_range(1, 0)), 1'b0, 1'b1);
      collectResult(n % 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
